tb_resp_checker: RTL and testbench

Response-capture and check engine for the exhaustive-vector benchmark flow: the receiving end of the stimulus sequence that applies every input combination, in ascending order, to a benchmark under test. It samples the DUT's single-bit response once per applied vector and builds a response map. It then compares that map serially against a golden map latched at start and reports pass/fail, mismatch count and first failing vector. It sits beside the DUT in the trojan-detection harness and lets a run be judged in hardware instead of by post-processing the text dump.

---
 rtl/tb_resp_checker_if.sv | 32 +++
 rtl/tb_resp_checker.sv | 104 ++++++++++
 tb/tb_tb_resp_checker.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/tb_resp_checker_if.sv
// Bundles the run control, golden map, vector/response stream and result outputs
// exchanged between a response-check engine and its driver.
interface tb_resp_checker_if #(
    parameter int N_IN = 4
);
    localparam int DEPTH = 2 ** N_IN;

    logic              start;
    logic              abort;
    logic [DEPTH-1:0]  golden;
    logic              vec_valid;
    logic [N_IN-1:0]   vec_in;
    logic              resp_in;

    logic              busy;
    logic              done;
    logic              pass;
    logic              seq_err;
    logic [N_IN:0]     mismatch_cnt;
    logic [N_IN-1:0]   first_fail_idx;
    logic [DEPTH-1:0]  resp_map;

    modport master (
        output start, abort, golden, vec_valid, vec_in, resp_in,
        input  busy, done, pass, seq_err, mismatch_cnt, first_fail_idx, resp_map
    );

    modport slave (
        input  start, abort, golden, vec_valid, vec_in, resp_in,
        output busy, done, pass, seq_err, mismatch_cnt, first_fail_idx, resp_map
    );
endinterface

// File: rtl/tb_resp_checker.sv
// Captures a DUT's one-bit response to every input vector of an exhaustive sweep,
// then compares the captured map against a latched golden map one bit per cycle.
module tb_resp_checker #(
    parameter int N_IN = 4
) (
    input logic             CK,
    input logic             reset,
    tb_resp_checker_if.slave bus
);
    localparam int DEPTH = 2 ** N_IN;
    localparam logic [N_IN:0]   LAST_EXP = (N_IN + 1)'(DEPTH - 1);
    localparam logic [N_IN-1:0] LAST_IDX = N_IN'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, CAPTURE, CHECK, DONE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              start_ok;
    logic              bit_diff;

    logic [DEPTH-1:0]  golden_q;
    logic [DEPTH-1:0]  resp_map_q;
    logic [N_IN:0]     exp_idx;
    logic [N_IN-1:0]   chk_idx;
    logic [N_IN:0]     mismatch_q;
    logic [N_IN-1:0]   first_fail_q;
    logic              seq_err_q;

    always_ff @(posedge CK or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // abort outranks start and vec_valid; start only counts from IDLE or DONE
    always_comb begin
        state_nxt = state;
        start_ok  = 1'b0;
        bit_diff  = resp_map_q[chk_idx] ^ golden_q[chk_idx];
        if (bus.abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        start_ok  = 1'b1;
                        state_nxt = CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (bus.vec_valid && exp_idx == LAST_EXP) state_nxt = CHECK;
                end
                CHECK: begin
                    if (chk_idx == LAST_IDX) state_nxt = DONE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            golden_q     <= '0;
            resp_map_q   <= '0;
            exp_idx      <= '0;
            chk_idx      <= '0;
            mismatch_q   <= '0;
            first_fail_q <= '0;
            seq_err_q    <= 1'b0;
        end else if (bus.abort) begin
            resp_map_q   <= '0;
            mismatch_q   <= '0;
            first_fail_q <= '0;
            seq_err_q    <= 1'b0;
        end else if (start_ok) begin
            golden_q     <= bus.golden;
            resp_map_q   <= '0;
            exp_idx      <= '0;
            chk_idx      <= '0;
            mismatch_q   <= '0;
            first_fail_q <= '0;
            seq_err_q    <= 1'b0;
        end else if (state == CAPTURE && bus.vec_valid) begin
            // Out-of-order vectors still land in the map; they only flag seq_err
            resp_map_q[bus.vec_in] <= bus.resp_in;
            if ({1'b0, bus.vec_in} != exp_idx) seq_err_q <= 1'b1;
            exp_idx <= exp_idx + 1'b1;
            chk_idx <= '0;
        end else if (state == CHECK) begin
            if (bit_diff) begin
                mismatch_q <= mismatch_q + 1'b1;
                if (mismatch_q == '0) first_fail_q <= chk_idx;
            end
            chk_idx <= chk_idx + 1'b1;
        end
    end

    assign bus.busy           = (state == CAPTURE) || (state == CHECK);
    assign bus.done           = (state == DONE);
    assign bus.pass           = (state == DONE) && (mismatch_q == '0) && !seq_err_q;
    assign bus.seq_err        = seq_err_q;
    assign bus.mismatch_cnt   = mismatch_q;
    assign bus.first_fail_idx = first_fail_q;
    assign bus.resp_map       = resp_map_q;
endmodule

// File: tb/tb_tb_resp_checker.sv
// Directed bench for tb_resp_checker: clean runs, mismatches, out-of-order vectors,
// abort, ignored start and asynchronous reset during CHECK.
module tb_tb_resp_checker;
    localparam int N_IN  = 4;
    localparam int DEPTH = 16;

    logic CK = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    tb_resp_checker_if #(.N_IN(N_IN)) bus ();

    tb_resp_checker #(.N_IN(N_IN)) dut (
        .CK    (CK),
        .reset (reset),
        .bus   (bus)
    );

    always #5 CK = ~CK;

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [15:0] g);
        bus.golden = g;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
    endtask

    task automatic send(input int v, input logic r);
        bus.vec_valid = 1'b1;
        bus.vec_in    = v[3:0];
        bus.resp_in   = r;
        tick();
        bus.vec_valid = 1'b0;
        bus.resp_in   = 1'b0;
    endtask

    // Edges from the last accepted vector until done rises; CHECK spends one edge per bit
    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!bus.done && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, n, DEPTH);
    endtask

    task automatic send_all(input logic [15:0] pat);
        for (int i = 0; i < DEPTH; i++) send(i, pat[i]);
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.golden    = '0;
        bus.vec_valid = 1'b0;
        bus.vec_in    = '0;
        bus.resp_in   = 1'b0;
        reset         = 1'b0;
        tick();
        tick();
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_pass", bus.pass, 0);
        chk("rst_seq_err", bus.seq_err, 0);
        chk("rst_mismatch", bus.mismatch_cnt, 0);
        chk("rst_ffi", bus.first_fail_idx, 0);
        chk("rst_map", bus.resp_map, 0);
        reset = 1'b1;
        tick();

        // Clean all-zero run
        do_start(16'h0000);
        chk("t1_busy", bus.busy, 1);
        send_all(16'h0000);
        chk("t1_busy_check", bus.busy, 1);
        chk("t1_done_early", bus.done, 0);
        wait_done("t1");
        chk("t1_pass", bus.pass, 1);
        chk("t1_mismatch", bus.mismatch_cnt, 0);
        chk("t1_seq_err", bus.seq_err, 0);
        chk("t1_map", bus.resp_map, 16'h0000);
        chk("t1_busy_done", bus.busy, 0);

        // Restart from DONE: responses at the two end vectors
        do_start(16'h8001);
        chk("t2_done_clr", bus.done, 0);
        send_all(16'h8001);
        wait_done("t2");
        chk("t2_pass", bus.pass, 1);
        chk("t2_map", bus.resp_map, 16'h8001);

        // Two mismatching bits
        do_start(16'h0000);
        send_all(16'h0220);
        wait_done("t3");
        chk("t3_pass", bus.pass, 0);
        chk("t3_mismatch", bus.mismatch_cnt, 2);
        chk("t3_ffi", bus.first_fail_idx, 5);
        chk("t3_map", bus.resp_map, 16'h0220);

        // Vectors 2 and 3 swapped, responses matching golden
        do_start(16'h00AC);
        for (int i = 0; i < DEPTH; i++) begin
            int v;
            v = (i == 2) ? 3 : (i == 3) ? 2 : i;
            send(v, bit'(16'h00AC >> v));
        end
        wait_done("t4");
        chk("t4_seq_err", bus.seq_err, 1);
        chk("t4_pass", bus.pass, 0);
        chk("t4_mismatch", bus.mismatch_cnt, 0);
        chk("t4_map", bus.resp_map, 16'h00AC);

        // Abort after 7 vectors
        do_start(16'h0000);
        for (int i = 0; i < 7; i++) send(i, 1'b1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("t5_abort_busy", bus.busy, 0);
        chk("t5_abort_done", bus.done, 0);
        chk("t5_abort_map", bus.resp_map, 0);

        // Fresh run with a start pulse in the middle of CAPTURE
        do_start(16'h1234);
        for (int i = 0; i < 7; i++) send(i, bit'(16'h1234 >> i));
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("t5_busy_mid", bus.busy, 1);
        for (int i = 7; i < DEPTH; i++) send(i, bit'(16'h1234 >> i));
        wait_done("t5");
        chk("t5_pass", bus.pass, 1);
        chk("t5_mismatch", bus.mismatch_cnt, 0);
        chk("t5_map", bus.resp_map, 16'h1234);

        // Asynchronous reset pulse during CHECK
        do_start(16'h0000);
        send_all(16'hFFFF);
        tick();
        tick();
        tick();
        chk("t6_mismatch_pre", bus.mismatch_cnt, 3);
        #2 reset = 1'b0;
        #1;
        chk("t6_busy_low", bus.busy, 0);
        chk("t6_mismatch_low", bus.mismatch_cnt, 0);
        chk("t6_map_low", bus.resp_map, 0);
        #2 reset = 1'b1;
        #1;
        chk("t6_done_rel", bus.done, 0);
        chk("t6_ffi_rel", bus.first_fail_idx, 0);
        chk("t6_seq_err_rel", bus.seq_err, 0);
        chk("t6_pass_rel", bus.pass, 0);
        send(0, 1'b1);
        tick();
        chk("t6_idle_busy", bus.busy, 0);
        chk("t6_idle_map", bus.resp_map, 0);
        chk("t6_idle_done", bus.done, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
